// File: rtl/case_convert_pkg.sv
`default_nettype none
// ============================================================================
// Module   : case_convert_pkg
// Brief    : Shared mode encodings, ASCII letter bounds and letter classifiers
//            for the streaming case converter.
// Revision : 1.0 - initial release
// ============================================================================
package case_convert_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_UPPER  = 2'b01,
        MODE_LOWER  = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_t;

    localparam logic [7:0] UC_LO = 8'h41;
    localparam logic [7:0] UC_HI = 8'h5A;
    localparam logic [7:0] LC_LO = 8'h61;
    localparam logic [7:0] LC_HI = 8'h7A;

    // Bit that distinguishes upper- from lower-case ASCII letters.
    localparam int CASE_BIT = 5;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= UC_LO) && (c <= UC_HI);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= LC_LO) && (c <= LC_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/case_convert_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : case_convert_stream_if
// Brief    : Input and output valid/ready streams of the case converter.
//            slave = converter side, master = producer/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface case_convert_stream_if #(
    parameter int LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic [1:0]           in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/case_convert_lane.sv
`default_nettype none
// ============================================================================
// Module   : case_convert_lane
// Brief    : Combinational single-character case conversion with a flag that
//            reports whether the character was altered.
// Revision : 1.0 - initial release
// ============================================================================
module case_convert_lane
    import case_convert_pkg::*;
(
    input  logic [7:0] in_char,
    input  mode_t      mode,
    output logic [7:0] out_char,
    output logic       changed
);

    logic [7:0] w_char;

    // Only letters are touched; everything else falls through unchanged.
    always_comb begin
        w_char = in_char;
        case (mode)
            MODE_UPPER:  if (is_lower(in_char)) w_char[CASE_BIT] = 1'b0;
            MODE_LOWER:  if (is_upper(in_char)) w_char[CASE_BIT] = 1'b1;
            MODE_TOGGLE: if (is_upper(in_char) || is_lower(in_char))
                             w_char[CASE_BIT] = ~in_char[CASE_BIT];
            default:     w_char = in_char;
        endcase
    end

    assign out_char = w_char;
    assign changed  = (w_char != in_char);

endmodule
`default_nettype wire

// File: rtl/case_convert_stream.sv
`default_nettype none
// ============================================================================
// Module   : case_convert_stream
// Brief    : LANES-wide streaming ASCII case converter with output register,
//            2-entry skid buffer and saturating changed-character counter.
// Revision : 1.0 - initial release
// ============================================================================
module case_convert_stream
    import case_convert_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
)(
    input  logic                   clk,
    input  logic                   rst,
    case_convert_stream_if.slave   bus,
    input  logic                   count_clr,
    output logic [CNT_W-1:0]       conv_count
);

    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] c_cnt_max = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [8*LANES-1:0] w_conv;
    logic [LANES-1:0]   w_chg;
    logic [PC_W-1:0]    w_pop;
    logic [SUM_W-1:0]   w_sum;
    logic               w_accept;
    logic               w_advance;

    logic               r_or_valid;
    logic [8*LANES-1:0] r_or_data;
    logic               r_sr_valid;
    logic [8*LANES-1:0] r_sr_data;
    logic               r_in_ready;
    logic [CNT_W-1:0]   r_count;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        case_convert_lane u_lane (
            .in_char  (bus.in_data[8*g +: 8]),
            .mode     (mode_t'(bus.in_mode)),
            .out_char (w_conv[8*g +: 8]),
            .changed  (w_chg[g])
        );
    end

    assign w_accept  = bus.in_valid && r_in_ready;
    assign w_advance = !r_or_valid || bus.out_ready;

    // Popcount of altered lanes, then saturating add onto the (possibly cleared) count.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + PC_W'(w_chg[i]);
        end
        w_sum = (count_clr ? '0 : SUM_W'(r_count))
              + (w_accept ? SUM_W'(w_pop) : '0);
    end

    // Output register and skid register; SR only fills while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_or_valid <= 1'b0;
            r_or_data  <= '0;
            r_sr_valid <= 1'b0;
            r_sr_data  <= '0;
            r_in_ready <= 1'b1;
        end else if (w_advance) begin
            if (r_sr_valid) begin
                r_or_data  <= r_sr_data;
                r_or_valid <= 1'b1;
                r_sr_valid <= 1'b0;
                r_in_ready <= 1'b1;
            end else if (w_accept) begin
                r_or_data  <= w_conv;
                r_or_valid <= 1'b1;
            end else begin
                r_or_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_sr_data  <= w_conv;
            r_sr_valid <= 1'b1;
            r_in_ready <= 1'b0;
        end
    end

    // Changed-character counter, updated at acceptance time and clamped at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept || count_clr) begin
            r_count <= (w_sum > c_cnt_max) ? c_cnt_max[CNT_W-1:0] : w_sum[CNT_W-1:0];
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_or_valid;
    assign bus.out_data  = r_or_data;
    assign conv_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_case_convert_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_case_convert_stream
// Brief    : Self-checking bench: queue-based reference model compared every
//            cycle, plus directed vectors with literal expectations. A second
//            instance with a 4-bit counter exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_case_convert_stream;
    import case_convert_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        count_clr = 1'b0;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    case_convert_stream_if #(.LANES(4)) ifa ();
    case_convert_stream_if #(.LANES(4)) ifb ();

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.in_data   = ifa.in_data;
    assign ifb.in_mode   = ifa.in_mode;
    assign ifb.out_ready = ifa.out_ready;

    always #5 clk = ~clk;

    case_convert_stream #(.LANES(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .count_clr(count_clr), .conv_count(cnt_a)
    );
    case_convert_stream #(.LANES(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .count_clr(count_clr), .conv_count(cnt_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] conv_byte(input logic [7:0] c, input logic [1:0] m);
        bit up = (c >= 8'h41) && (c <= 8'h5A);
        bit lo = (c >= 8'h61) && (c <= 8'h7A);
        case (m)
            2'b01:   return lo ? c - 8'd32 : c;
            2'b10:   return up ? c + 8'd32 : c;
            2'b11:   return up ? c + 8'd32 : (lo ? c - 8'd32 : c);
            default: return c;
        endcase
    endfunction

    function automatic logic [31:0] conv_beat(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = conv_byte(d[8*i +: 8], m);
        return r;
    endfunction

    function automatic int n_changed(input logic [31:0] d, input logic [1:0] m);
        int n = 0;
        for (int i = 0; i < 4; i++) if (conv_byte(d[8*i +: 8], m) != d[8*i +: 8]) n++;
        return n;
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    logic [31:0] q[$];
    int unsigned m_cnt16 = 0;
    int unsigned m_cnt4  = 0;

    // Compare DUT state with the model each cycle, then advance the model.
    always @(negedge clk) begin
        bit acc;
        int unsigned inc;
        if (rst) begin
            q.delete();
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else begin
            chk("a_out_valid", 64'(ifa.out_valid), 64'(q.size() > 0));
            chk("b_out_valid", 64'(ifb.out_valid), 64'(q.size() > 0));
            chk("a_in_ready",  64'(ifa.in_ready),  64'(q.size() < 2));
            chk("b_in_ready",  64'(ifb.in_ready),  64'(q.size() < 2));
            if (q.size() > 0) begin
                chk("a_out_data", 64'(ifa.out_data), 64'(q[0]));
                chk("b_out_data", 64'(ifb.out_data), 64'(q[0]));
            end
            chk("a_count", 64'(cnt_a), 64'(m_cnt16));
            chk("b_count", 64'(cnt_b), 64'(m_cnt4));
            acc = ifa.in_valid && (q.size() < 2);
            if ((q.size() > 0) && ifa.out_ready) void'(q.pop_front());
            inc = acc ? n_changed(ifa.in_data, ifa.in_mode) : 0;
            if (acc) q.push_back(conv_beat(ifa.in_data, ifa.in_mode));
            if (count_clr) begin
                m_cnt16 = sat(inc, 65535);
                m_cnt4  = sat(inc, 15);
            end else if (acc) begin
                m_cnt16 = sat(m_cnt16 + inc, 65535);
                m_cnt4  = sat(m_cnt4 + inc, 15);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] d, input logic [1:0] m);
        int n = 0;
        ifa.in_valid = 1'b1;
        ifa.in_data  = d;
        ifa.in_mode  = m;
        while (!ifa.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] edges [8] = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 7)];
        return 8'($urandom);
    endfunction

    initial begin
        ifa.in_valid  = 1'b0;
        ifa.in_data   = '0;
        ifa.in_mode   = 2'b00;
        ifa.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_out_data",  64'(ifa.out_data),  64'd0);
        chk("rst_in_ready",  64'(ifa.in_ready),  64'd1);
        chk("rst_count",     64'(cnt_a),         64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic conversion, one-cycle latency.
        send(32'h7A61405B, 2'(MODE_UPPER));
        chk("upper_data",  64'(ifa.out_data), 64'h5A41405B);
        chk("upper_count", 64'(cnt_a), 64'd2);

        // Mode coverage.
        send(32'h4161317B, 2'(MODE_LOWER));
        chk("lower_data",  64'(ifa.out_data), 64'h6161317B);
        chk("lower_count", 64'(cnt_a), 64'd3);
        send(32'h4161317B, 2'(MODE_TOGGLE));
        chk("toggle_data",  64'(ifa.out_data), 64'h6141317B);
        chk("toggle_count", 64'(cnt_a), 64'd5);
        send(32'h4161317B, 2'(MODE_PASS));
        chk("pass_data",  64'(ifa.out_data), 64'h4161317B);
        chk("pass_count", 64'(cnt_a), 64'd5);
        @(posedge clk); #1;

        // Backpressure with three beats.
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 32'h61626364;
        ifa.in_mode   = 2'(MODE_UPPER);
        @(posedge clk); #1;
        chk("bp_first",     64'(ifa.out_data), 64'h41424344);
        chk("bp_ready1",    64'(ifa.in_ready), 64'd1);
        ifa.in_data = 32'h31323334;
        ifa.in_mode = 2'(MODE_PASS);
        @(posedge clk); #1;
        chk("bp_ready2",    64'(ifa.in_ready), 64'd0);
        ifa.in_data = 32'h7A7A7A7A;
        ifa.in_mode = 2'(MODE_TOGGLE);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_data",  64'(ifa.out_data),  64'h41424344);
        chk("bp_hold_valid", 64'(ifa.out_valid), 64'd1);
        chk("bp_hold_ready", 64'(ifa.in_ready),  64'd0);
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_second",    64'(ifa.out_data), 64'h31323334);
        chk("bp_ready_back",64'(ifa.in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_third",     64'(ifa.out_data), 64'h5A5A5A5A);
        chk("bp_count",     64'(cnt_a), 64'd13);
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;

        // Clear alone, then saturation on the 4-bit counter.
        count_clr = 1'b1;
        @(posedge clk); #1;
        count_clr = 1'b0;
        chk("clr_a", 64'(cnt_a), 64'd0);
        chk("clr_b", 64'(cnt_b), 64'd0);
        repeat (5) send(32'h61616161, 2'(MODE_UPPER));
        chk("sat_b", 64'(cnt_b), 64'd15);
        chk("sat_a", 64'(cnt_a), 64'd20);
        count_clr = 1'b1;
        send(32'h00006261, 2'(MODE_UPPER));
        count_clr = 1'b0;
        chk("clr_acc_a", 64'(cnt_a), 64'd2);
        chk("clr_acc_b", 64'(cnt_b), 64'd2);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset with OR and SR both full.
        ifa.out_ready = 1'b0;
        send(32'h41414141, 2'(MODE_LOWER));
        send(32'h42424242, 2'(MODE_LOWER));
        chk("pre_rst_ready", 64'(ifa.in_ready),  64'd0);
        chk("pre_rst_valid", 64'(ifa.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 64'(ifa.out_valid), 64'd0);
        chk("async_ready", 64'(ifa.in_ready),  64'd1);
        chk("async_count", 64'(cnt_a),         64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_stale", 64'(ifa.out_valid), 64'd0);

        // Random traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            ifa.in_valid  = 1'($urandom_range(0, 1));
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            ifa.in_mode   = 2'($urandom);
            ifa.in_data   = {pick_byte(), pick_byte(), pick_byte(), pick_byte()};
            count_clr     = ($urandom_range(0, 63) == 0);
            @(posedge clk); #1;
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        count_clr     = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_valid", 64'(ifa.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
